// File: rtl/dsp48a1_ctrl_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
// Holds the slice widths, the OPMODE field encodings and the controller state enum.
package dsp48a1_ctrl_pkg;

    localparam int unsigned AB_W  = 18;
    localparam int unsigned P_W   = 48;
    localparam int unsigned OPM_W = 8;

    localparam logic [1:0] OPM_X_ZERO = 2'b00;
    localparam logic [1:0] OPM_X_M    = 2'b01;
    localparam logic [1:0] OPM_Z_ZERO = 2'b00;
    localparam logic [1:0] OPM_Z_P    = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_e;

    // A bubble adds zero to P; the first term of a job replaces stale P with M.
    function automatic logic [OPM_W-1:0] opmode_f(input logic v0, input logic first0);
        logic [1:0] x_s;
        logic [1:0] z_s;
        x_s = v0 ? OPM_X_M : OPM_X_ZERO;
        z_s = (v0 && first0) ? OPM_Z_ZERO : OPM_Z_P;
        return {4'b0000, z_s, x_s};
    endfunction

endpackage

// File: rtl/dsp48a1_issue_pipe.sv
// Operand issue stage: registers accepted operand pairs onto the slice A/B ports
// and produces OPMODE one cycle later so it meets the product at the post-adder.
module dsp48a1_issue_pipe
    import dsp48a1_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hs_i,
    input  logic              first_i,
    input  logic [AB_W-1:0]   a_i,
    input  logic [AB_W-1:0]   b_i,
    output logic [AB_W-1:0]   dsp_a_o,
    output logic [AB_W-1:0]   dsp_b_o,
    output logic [OPM_W-1:0]  dsp_opmode_o
);

    logic [AB_W-1:0]  a_q, a_d;
    logic [AB_W-1:0]  b_q, b_d;
    logic             v0_q, v0_d;
    logic             first0_q, first0_d;
    logic [OPM_W-1:0] opm_q, opm_d;

    // Next-state: operands hold between handshakes; OPMODE follows the issue flags.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        v0_d     = hs_i;
        first0_d = hs_i && first_i;
        opm_d    = opmode_f(v0_q, first0_q);
        if (hs_i) begin
            a_d = a_i;
            b_d = b_i;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
    end

    // Issue registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= {AB_W{1'b0}};
            b_q      <= {AB_W{1'b0}};
            v0_q     <= 1'b0;
            first0_q <= 1'b0;
            opm_q    <= {OPM_W{1'b0}};
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            v0_q     <= v0_d;
            first0_q <= first0_d;
            opm_q    <= opm_d;
        end
    end

    assign dsp_a_o      = a_q;
    assign dsp_b_o      = b_q;
    assign dsp_opmode_o = opm_q;

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Streams operand pairs through one DSP48A1 slice as a multiply-accumulator and
// returns the 48-bit sum once the slice pipeline has drained.
module dsp48a1_mac_sequencer
    import dsp48a1_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned DSP_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [AB_W-1:0]   s_a_i,
    input  logic [AB_W-1:0]   s_b_i,
    output logic [AB_W-1:0]   dsp_a_o,
    output logic [AB_W-1:0]   dsp_b_o,
    output logic [OPM_W-1:0]  dsp_opmode_o,
    output logic              dsp_ce_o,
    output logic              dsp_rst_o,
    input  logic [P_W-1:0]    dsp_p_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [P_W-1:0]    res_data_o
);

    localparam int unsigned CNT_W = 4;

    state_e             state_q;
    logic               busy_q;
    logic               s_ready_q;
    logic               dsp_ce_q;
    logic               dsp_rst_q;
    logic               res_valid_q;
    logic [P_W-1:0]     res_data_q;
    logic [LEN_W-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               first_pend_q;
    logic               hs_s;

    assign hs_s = s_valid_i && s_ready_q;

    dsp48a1_issue_pipe u_issue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hs_i         (hs_s),
        .first_i      (first_pend_q),
        .a_i          (s_a_i),
        .b_i          (s_b_i),
        .dsp_a_o      (dsp_a_o),
        .dsp_b_o      (dsp_b_o),
        .dsp_opmode_o (dsp_opmode_o)
    );

    // Job FSM; outputs are registered from the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            dsp_ce_q     <= 1'b0;
            dsp_rst_q    <= 1'b1;
            res_valid_q  <= 1'b0;
            res_data_q   <= {P_W{1'b0}};
            rem_q        <= {LEN_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            first_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dsp_rst_q <= 1'b0;
                    dsp_ce_q  <= 1'b1;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (len_i != {LEN_W{1'b0}}) begin
                            rem_q     <= len_i;
                            dsp_rst_q <= 1'b1;
                            dsp_ce_q  <= 1'b0;
                            state_q   <= CLR;
                        end else begin
                            res_data_q  <= {P_W{1'b0}};
                            res_valid_q <= 1'b1;
                            state_q     <= RESULT;
                        end
                    end
                end
                CLR: begin
                    dsp_rst_q    <= 1'b0;
                    dsp_ce_q     <= 1'b1;
                    s_ready_q    <= 1'b1;
                    first_pend_q <= 1'b1;
                    state_q      <= FEED;
                end
                FEED: begin
                    if (hs_s) begin
                        rem_q        <= rem_q - LEN_W'(1);
                        first_pend_q <= 1'b0;
                        if (rem_q == LEN_W'(1)) begin
                            s_ready_q <= 1'b0;
                            cnt_q     <= {CNT_W{1'b0}};
                            state_q   <= DRAIN;
                        end
                    end
                end
                // Wait out the slice latency plus the skewed OPMODE stage.
                DRAIN: begin
                    if (cnt_q == CNT_W'(DSP_LAT)) begin
                        res_data_q  <= dsp_p_i;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    s_ready_q   <= 1'b0;
                    res_valid_q <= 1'b0;
                    dsp_rst_q   <= 1'b1;
                    dsp_ce_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign s_ready_o   = s_ready_q;
    assign dsp_ce_o    = dsp_ce_q;
    assign dsp_rst_o   = dsp_rst_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;

endmodule

// File: doc/dsp48a1_mac_sequencer.md
Name: dsp48a1_mac_sequencer

Overview:
Controller that runs the DSP48A1 slice as a streaming multiply-accumulator: sum(A_i*B_i) for i=0..len-1.
- Accepts a job (start + len), pulls operand pairs over a valid/ready stream, and drives the slice's A/B/OPMODE/CE/RST.
- Compensates the slice pipeline and returns the 48-bit P result over a valid/ready result port.
- Sits between the stream source and one DSP48A1 instance. The slice is configured A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT=DIRECT, CARRYIN unused (tied 0).

Parameters:
LEN_W, 16, width of len (max job length 2^LEN_W-1)
DSP_LAT, 3, slice latency from A/B port to registered P output (fixed by slice configuration)

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  reset, asynchronous, active-high
start  in  1  job request, sampled in IDLE only
len  in  LEN_W  number of operand pairs, sampled with start
busy  out  1  high in every state except IDLE
s_valid  in  1  operand pair valid
s_ready  out  1  sequencer accepts operand pair
s_a  in  18  signed operand A
s_b  in  18  signed operand B
dsp_a  out  18  to slice A
dsp_b  out  18  to slice B
dsp_opmode  out  8  to slice OPMODE
dsp_ce  out  1  drives all slice CE* inputs
dsp_rst  out  1  drives all slice RST* inputs
dsp_p  in  48  slice P output
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  48  signed accumulated result

Behaviour:
- Reset values: busy=0, s_ready=0, dsp_a=0, dsp_b=0, dsp_opmode=0, dsp_ce=0, dsp_rst=1, res_valid=0, res_data=0. All outputs are registered.
- State IDLE: dsp_rst=0, dsp_ce=1.
  - start=1, len>0: latch len into remaining counter; go to CLR.
  - start=1, len=0: set res_data=0; go to RESULT (res_valid high in next cycle).
- State CLR: exactly 1 cycle. dsp_rst=1, dsp_ce=0, flushing all slice registers. Next state FEED.
- State FEED: dsp_ce=1, dsp_rst=0. s_ready=1 while remaining>0.
  - A handshake (s_valid&&s_ready) in cycle h registers s_a/s_b onto dsp_a/dsp_b for cycle h+1, with issue flag v0=1. first0=1 for the job's first pair.
  - With no handshake: v0=0; dsp_a/dsp_b hold their previous values.
  - On the handshake that makes remaining=0: s_ready drops in the next cycle; go to DRAIN.
- OPMODE issue, skewed one cycle after the operands so it meets M at the post-adder. In cycle h+2, dsp_opmode is:
  - X[1:0] = v0 ? 2'b01 (M) : 2'b00 (zero).
  - Z[3:2] = (v0&&first0) ? 2'b00 : 2'b10 (P).
  - bits[7:4] = 0 (no pre-adder, add, no carry).
  - Bubbles therefore leave P unchanged (0+P). The first term clears stale P.
- State DRAIN: dsp_ce=1; OPMODE continues to hold P. Counts DSP_LAT+1 cycles after the last handshake, then captures dsp_p into res_data and goes to RESULT.
- Timing: res_valid rises exactly DSP_LAT+2 = 5 cycles after the last handshake cycle.
- State RESULT: res_valid=1, res_data stable. On res_ready=1: res_valid=0 next cycle, go to IDLE. start is ignored outside IDLE.
- Arithmetic: 18x18 signed product, 48-bit two's-complement accumulation. Overflow wraps silently; there is no flag.
- RST asserted in any state: immediate return to reset values. The in-flight job is discarded, no result is produced, and dsp_rst stays 1 until the first clock after RST deasserts.
- s_valid while not in FEED: ignored, s_ready=0.

Decomposition:
- Package dsp48a1_ctrl_pkg:
  - OPMODE field constants: OPM_X_ZERO=2'b00, OPM_X_M=2'b01, OPM_Z_ZERO=2'b00, OPM_Z_P=2'b10.
  - State enum: IDLE, CLR, FEED, DRAIN, RESULT.
  - Slice widths: 18, 48.
- One sub-module, dsp48a1_issue_pipe: registers operands, the v0/first0 flags, and the one-cycle-skewed OPMODE generation.
- The FSM, counters, and result register stay in the top.

Test Plan:
Bench instantiates the sequencer wired to a DSP48A1 with the stated configuration.
- Continuous stream: len=3, pairs (1,2),(3,4),(5,6), s_valid held high -> res_data=44, res_valid exactly 5 cycles after the third handshake.
- Bubbles: same pairs with s_valid low 2 cycles between pairs -> res_data=44; P unchanged during bubbles.
- Signed values: len=2, pairs (-3,7),(2,5) -> res_data=48'hFFFF_FFFF_FFF5 (-11).
- len=0 -> no s_ready pulse, res_valid in the cycle after start, res_data=0.
- Result backpressure and back-to-back jobs:
  - Hold res_ready=0 for 4 cycles with start=1 -> res_data stable, start ignored.
  - Then a job with len=1, pair (10,10) -> res_data=100 (previous 44 not accumulated).
- Reset mid-job: RST pulse during FEED after 1 of 3 pairs -> all outputs at reset values, no res_valid. A new job with len=1, pair (4,4) -> res_data=16.
